// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the AXI3 request issuer.
package apb2axi_pkg;

  localparam int TAG_W           = 4;
  localparam int AXI_ID_W        = 4;
  localparam int AXI_ADDR_W      = 32;
  localparam int AXI_DATA_W      = 64;
  localparam int AXI_STRB_W      = AXI_DATA_W / 8;
  localparam int WD_W            = AXI_DATA_W + AXI_STRB_W;
  localparam int MAX_OUTSTANDING = 8;
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  // Every beat uses the full bus width.
  localparam logic [2:0] AXI_SIZE_FULL  = 3'($clog2(AXI_STRB_W));

  typedef struct packed {
    logic                  is_write;
    logic [TAG_W-1:0]      tag;
    logic [AXI_ADDR_W-1:0] addr;
    logic [3:0]            len;
  } req_entry_t;

  localparam int REQ_W = $bits(req_entry_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_AW   = 2'd2,
    ST_W    = 2'd3
  } state_t;

  // True when a full-width INCR burst starting at addr stays inside one 4KB page.
  function automatic logic burst_in_4k(input logic [AXI_ADDR_W-1:0] addr,
                                       input logic [3:0] len);
    logic [12:0] bytes;
    bytes = (13'(len) + 13'd1) << AXI_SIZE_FULL;
    return ({1'b0, addr[11:0]} + bytes) <= 13'h1000;
  endfunction

endpackage

// File: rtl/axi_req_issuer.sv
// AXI3 master request side: pops one request at a time, issues AR or AW+W,
// and caps issued-but-uncompleted transactions at MAX_OUTSTANDING.
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid and ready are both high; a raised valid and its payload stay
// stable until that transfer, and no valid is derived from its own ready.
module axi_req_issuer
  import apb2axi_pkg::*;
(
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  req_valid,
  input  logic [REQ_W-1:0]      req_data,
  output logic                  req_ready,
  input  logic                  wd_valid,
  input  logic [WD_W-1:0]       wd_data,
  output logic                  wd_ready,
  output logic [AXI_ID_W-1:0]   awid,
  output logic [AXI_ADDR_W-1:0] awaddr,
  output logic [3:0]            awlen,
  output logic [1:0]            awburst,
  output logic [2:0]            awsize,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [AXI_ID_W-1:0]   wid,
  output logic [AXI_DATA_W-1:0] wdata,
  output logic [AXI_STRB_W-1:0] wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [AXI_ID_W-1:0]   arid,
  output logic [AXI_ADDR_W-1:0] araddr,
  output logic [3:0]            arlen,
  output logic [1:0]            arburst,
  output logic [2:0]            arsize,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic                  rsp_done,
  output logic [1:0]            dbg_state,
  output logic [CNT_W-1:0]      dbg_out_cnt
);

  state_t                r_state;
  logic [AXI_ID_W-1:0]   r_id;
  logic [AXI_ADDR_W-1:0] r_addr;
  logic [3:0]            r_len;
  logic [3:0]            r_beat_cnt;
  logic                  r_arvalid;
  logic                  r_awvalid;
  logic [CNT_W-1:0]      r_out_cnt;

  req_entry_t w_req;
  logic       w_pop;
  logic       w_ar_hs;
  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_inc;
  logic       w_dec;
  logic       w_last_beat;

  assign w_req = req_data;

  // Pop only from IDLE with room in the outstanding window.
  assign req_ready = !areset && (r_state == ST_IDLE) && req_valid &&
                     (r_out_cnt < CNT_W'(MAX_OUTSTANDING));
  assign w_pop     = req_ready;

  assign w_ar_hs     = r_arvalid && arready;
  assign w_aw_hs     = r_awvalid && awready;
  assign w_last_beat = (r_beat_cnt == r_len);

  // W beats stream straight from the write-data FIFO once AW has been accepted;
  // the FIFO is popped only on an actual W transfer so an empty FIFO is never popped.
  assign wvalid   = (r_state == ST_W) && wd_valid;
  assign w_w_hs   = wvalid && wready;
  assign wd_ready = w_w_hs;
  assign wlast    = (r_state == ST_W) && w_last_beat;
  assign {wstrb, wdata} = wd_data;

  assign arvalid = r_arvalid;
  assign arid    = r_id;
  assign araddr  = r_addr;
  assign arlen   = r_len;
  assign arburst = AXI_BURST_INCR;
  assign arsize  = AXI_SIZE_FULL;

  assign awvalid = r_awvalid;
  assign awid    = r_id;
  assign awaddr  = r_addr;
  assign awlen   = r_len;
  assign awburst = AXI_BURST_INCR;
  assign awsize  = AXI_SIZE_FULL;
  assign wid     = r_id;

  assign dbg_state   = r_state;
  assign dbg_out_cnt = r_out_cnt;

  // Request sequencer: latch a popped entry, present it on AR or AW, then stream W.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state    <= ST_IDLE;
      r_id       <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_arvalid  <= 1'b0;
      r_awvalid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_id   <= AXI_ID_W'(w_req.tag);
            r_addr <= w_req.addr;
            r_len  <= w_req.len;
            if (w_req.is_write) begin
              r_awvalid <= 1'b1;
              r_state   <= ST_AW;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (w_ar_hs) begin
            r_arvalid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_AW: begin
          if (w_aw_hs) begin
            r_awvalid  <= 1'b0;
            r_beat_cnt <= '0;
            r_state    <= ST_W;
          end
        end
        ST_W: begin
          if (w_w_hs) begin
            r_beat_cnt <= r_beat_cnt + 4'd1;
            if (w_last_beat) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outstanding window: +1 per address handshake, -1 per completion, saturating at 0.
  assign w_inc = w_ar_hs || w_aw_hs;
  assign w_dec = rsp_done && (r_out_cnt != '0);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_out_cnt <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_out_cnt <= r_out_cnt + CNT_W'(1);
        2'b01:   r_out_cnt <= r_out_cnt - CNT_W'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

  a_rsp_underflow: assert property (@(posedge aclk) disable iff (areset)
    !(rsp_done && (r_out_cnt == '0)));

  a_req_in_4k: assert property (@(posedge aclk) disable iff (areset)
    w_pop |-> burst_in_4k(w_req.addr, w_req.len));

endmodule

// File: tb/tb_axi_req_issuer.sv
// Directed bench for axi_req_issuer: cycle table for a read and a gapped write,
// then hand-written sequences for back-pressure, window limit and reset.
module tb_axi_req_issuer;
  import apb2axi_pkg::*;

  logic                  aclk = 1'b0;
  logic                  areset = 1'b1;
  logic                  req_valid = 1'b0;
  logic [REQ_W-1:0]      req_data = '0;
  logic                  req_ready;
  logic                  wd_valid = 1'b0;
  logic [WD_W-1:0]       wd_data = '0;
  logic                  wd_ready;
  logic [AXI_ID_W-1:0]   awid;
  logic [AXI_ADDR_W-1:0] awaddr;
  logic [3:0]            awlen;
  logic [1:0]            awburst;
  logic [2:0]            awsize;
  logic                  awvalid;
  logic                  awready = 1'b0;
  logic [AXI_ID_W-1:0]   wid;
  logic [AXI_DATA_W-1:0] wdata;
  logic [AXI_STRB_W-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready = 1'b0;
  logic [AXI_ID_W-1:0]   arid;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [3:0]            arlen;
  logic [1:0]            arburst;
  logic [2:0]            arsize;
  logic                  arvalid;
  logic                  arready = 1'b0;
  logic                  rsp_done = 1'b0;
  logic [1:0]            dbg_state;
  logic [CNT_W-1:0]      dbg_out_cnt;

  // Clock
  always #5 aclk = ~aclk;

  axi_req_issuer dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .wd_valid(wd_valid), .wd_data(wd_data), .wd_ready(wd_ready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awsize(awsize),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rsp_done(rsp_done), .dbg_state(dbg_state), .dbg_out_cnt(dbg_out_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [AXI_DATA_W-1:0] exp_q[$];

  // ctl = {areset, req_valid, is_write, wd_valid, awready, wready, arready, rsp_done}
  // exp = {req_ready, arvalid, awvalid, wvalid, wlast, wd_ready}
  typedef struct {
    logic [7:0]  ctl;
    logic [3:0]  tag;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [63:0] wd;
    logic [5:0]  exp;
    logic [1:0]  st;
    logic [3:0]  cnt;
    logic [3:0]  e_id;
    logic [31:0] e_addr;
    logic [3:0]  e_len;
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge aclk);
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    wd_valid  = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    arready   = 1'b0;
    rsp_done  = 1'b0;
  endtask

  task automatic set_req(input logic v, input logic wr, input logic [3:0] tag,
                         input logic [31:0] addr, input logic [3:0] len);
    req_entry_t e;
    e.is_write = wr;
    e.tag      = tag;
    e.addr     = addr;
    e.len      = len;
    req_data   = e;
    req_valid  = v;
  endtask

  task automatic set_wd(input logic v, input logic [63:0] d);
    wd_valid = v;
    wd_data  = {d[7:0], d};
  endtask

  initial begin
    // Read tag 3 then write tag 5 (len 3) with wready toggling and a wd_valid gap.
    tbl[0]  = '{8'b1100_0000, 4'd3, 32'h1000, 4'd3, 64'd0,                  6'b000000, ST_IDLE, 4'd0, 4'd0, 32'h0,    4'd0};
    tbl[1]  = '{8'b0100_0010, 4'd3, 32'h1000, 4'd3, 64'd0,                  6'b100000, ST_IDLE, 4'd0, 4'd0, 32'h0,    4'd0};
    tbl[2]  = '{8'b0000_0010, 4'd0, 32'h0,    4'd0, 64'd0,                  6'b010000, ST_AR,   4'd0, 4'd3, 32'h1000, 4'd3};
    tbl[3]  = '{8'b0110_0000, 4'd5, 32'h2000, 4'd3, 64'd0,                  6'b100000, ST_IDLE, 4'd1, 4'd3, 32'h1000, 4'd3};
    tbl[4]  = '{8'b0001_1000, 4'd0, 32'h0,    4'd0, 64'h1111_2222_3333_44A0, 6'b001000, ST_AW,   4'd1, 4'd5, 32'h2000, 4'd3};
    tbl[5]  = '{8'b0001_0100, 4'd0, 32'h0,    4'd0, 64'h1111_2222_3333_44A0, 6'b000101, ST_W,    4'd2, 4'd5, 32'h2000, 4'd3};
    tbl[6]  = '{8'b0001_0000, 4'd0, 32'h0,    4'd0, 64'h5555_6666_7777_88B1, 6'b000100, ST_W,    4'd2, 4'd5, 32'h2000, 4'd3};
    tbl[7]  = '{8'b0001_0100, 4'd0, 32'h0,    4'd0, 64'h5555_6666_7777_88B1, 6'b000101, ST_W,    4'd2, 4'd5, 32'h2000, 4'd3};
    tbl[8]  = '{8'b0000_0100, 4'd0, 32'h0,    4'd0, 64'h9999_AAAA_BBBB_CCC2, 6'b000000, ST_W,    4'd2, 4'd5, 32'h2000, 4'd3};
    tbl[9]  = '{8'b0001_0000, 4'd0, 32'h0,    4'd0, 64'h9999_AAAA_BBBB_CCC2, 6'b000100, ST_W,    4'd2, 4'd5, 32'h2000, 4'd3};
    tbl[10] = '{8'b0001_0100, 4'd0, 32'h0,    4'd0, 64'h9999_AAAA_BBBB_CCC2, 6'b000101, ST_W,    4'd2, 4'd5, 32'h2000, 4'd3};
    tbl[11] = '{8'b0001_0000, 4'd0, 32'h0,    4'd0, 64'hDDDD_EEEE_FFFF_00D3, 6'b000110, ST_W,    4'd2, 4'd5, 32'h2000, 4'd3};
    tbl[12] = '{8'b0001_0100, 4'd0, 32'h0,    4'd0, 64'hDDDD_EEEE_FFFF_00D3, 6'b000111, ST_W,    4'd2, 4'd5, 32'h2000, 4'd3};
    tbl[13] = '{8'b0000_0001, 4'd0, 32'h0,    4'd0, 64'd0,                  6'b000000, ST_IDLE, 4'd2, 4'd5, 32'h2000, 4'd3};
    tbl[14] = '{8'b0000_0001, 4'd0, 32'h0,    4'd0, 64'd0,                  6'b000000, ST_IDLE, 4'd1, 4'd5, 32'h2000, 4'd3};
    tbl[15] = '{8'b0000_0000, 4'd0, 32'h0,    4'd0, 64'd0,                  6'b000000, ST_IDLE, 4'd0, 4'd5, 32'h2000, 4'd3};

    exp_q.push_back(64'h1111_2222_3333_44A0);
    exp_q.push_back(64'h5555_6666_7777_88B1);
    exp_q.push_back(64'h9999_AAAA_BBBB_CCC2);
    exp_q.push_back(64'hDDDD_EEEE_FFFF_00D3);

    for (int i = 0; i < 16; i++) begin
      nxt();
      areset  = tbl[i].ctl[7];
      set_req(tbl[i].ctl[6], tbl[i].ctl[5], tbl[i].tag, tbl[i].addr, tbl[i].len);
      set_wd(tbl[i].ctl[4], tbl[i].wd);
      awready  = tbl[i].ctl[3];
      wready   = tbl[i].ctl[2];
      arready  = tbl[i].ctl[1];
      rsp_done = tbl[i].ctl[0];
      #1;
      check($sformatf("v%0d req_ready", i), req_ready, tbl[i].exp[5]);
      check($sformatf("v%0d arvalid", i),   arvalid,   tbl[i].exp[4]);
      check($sformatf("v%0d awvalid", i),   awvalid,   tbl[i].exp[3]);
      check($sformatf("v%0d wvalid", i),    wvalid,    tbl[i].exp[2]);
      check($sformatf("v%0d wlast", i),     wlast,     tbl[i].exp[1]);
      check($sformatf("v%0d wd_ready", i),  wd_ready,  tbl[i].exp[0]);
      check($sformatf("v%0d state", i),     dbg_state, tbl[i].st);
      check($sformatf("v%0d out_cnt", i),   dbg_out_cnt, tbl[i].cnt);
      check($sformatf("v%0d arid", i),      arid,   tbl[i].e_id);
      check($sformatf("v%0d awid", i),      awid,   tbl[i].e_id);
      check($sformatf("v%0d wid", i),       wid,    tbl[i].e_id);
      check($sformatf("v%0d araddr", i),    araddr, tbl[i].e_addr);
      check($sformatf("v%0d awaddr", i),    awaddr, tbl[i].e_addr);
      check($sformatf("v%0d arlen", i),     arlen,  tbl[i].e_len);
      check($sformatf("v%0d awlen", i),     awlen,  tbl[i].e_len);
      if (wvalid && wready) begin
        if (exp_q.size() == 0) begin
          check($sformatf("v%0d extra W beat", i), 64'd1, 64'd0);
        end else begin
          check($sformatf("v%0d wdata", i), wdata, exp_q.pop_front());
          check($sformatf("v%0d wstrb", i), wstrb, tbl[i].wd[7:0]);
        end
      end
    end
    check("W beats outstanding", 64'(exp_q.size()), 64'd0);
    check("awburst", awburst, 2'b01);
    check("awsize",  awsize,  3'd3);
    check("arburst", arburst, 2'b01);
    check("arsize",  arsize,  3'd3);

    // AW back-pressure: 10 cycles of awready=0 with data already waiting.
    nxt(); idle_inputs(); set_req(1'b1, 1'b1, 4'd9, 32'h3000, 4'd0); #1;
    check("bp pop", req_ready, 1'b1);
    for (int k = 0; k < 10; k++) begin
      nxt(); set_req(1'b1, 1'b1, 4'd9, 32'h3000, 4'd0); set_wd(1'b1, 64'hCAFE_0000_0000_0077); #1;
      check($sformatf("bp%0d awvalid", k), awvalid, 1'b1);
      check($sformatf("bp%0d awaddr", k),  awaddr,  32'h3000);
      check($sformatf("bp%0d awid", k),    awid,    4'd9);
      check($sformatf("bp%0d wvalid", k),  wvalid,  1'b0);
      check($sformatf("bp%0d req_ready", k), req_ready, 1'b0);
    end
    nxt(); req_valid = 1'b0; awready = 1'b1; #1;
    check("bp aw hs", awvalid, 1'b1);
    nxt(); awready = 1'b0; wready = 1'b1; #1;
    check("bp wvalid", wvalid, 1'b1);
    check("bp wlast",  wlast,  1'b1);
    check("bp wdata",  wdata,  64'hCAFE_0000_0000_0077);
    nxt(); idle_inputs(); rsp_done = 1'b1; #1;
    check("bp state idle", dbg_state, ST_IDLE);
    check("bp cnt 1", dbg_out_cnt, 4'd1);
    nxt(); rsp_done = 1'b0; #1;
    check("bp cnt 0", dbg_out_cnt, 4'd0);

    // Outstanding window: 8 reads fill it, one completion re-opens it.
    for (int k = 0; k < 8; k++) begin
      nxt(); set_req(1'b1, 1'b0, 4'(k), 32'h4000 + 32'(k) * 32'h100, 4'd1); arready = 1'b1; #1;
      check($sformatf("rd%0d pop", k), req_ready, 1'b1);
      nxt(); req_valid = 1'b0; #1;
      check($sformatf("rd%0d arvalid", k), arvalid, 1'b1);
      check($sformatf("rd%0d arid", k),    arid,    4'(k));
      check($sformatf("rd%0d araddr", k),  araddr,  32'h4000 + 32'(k) * 32'h100);
    end
    for (int k = 0; k < 3; k++) begin
      nxt(); set_req(1'b1, 1'b0, 4'hA, 32'h5000, 4'd2); #1;
      check($sformatf("full%0d req_ready", k), req_ready, 1'b0);
      check($sformatf("full%0d cnt", k), dbg_out_cnt, 4'd8);
    end
    nxt(); rsp_done = 1'b1; #1;
    check("full done cycle req_ready", req_ready, 1'b0);
    nxt(); rsp_done = 1'b0; #1;
    check("reopen req_ready", req_ready, 1'b1);
    check("reopen cnt", dbg_out_cnt, 4'd7);
    nxt(); req_valid = 1'b0; arready = 1'b0; rsp_done = 1'b1; #1;
    check("9th arvalid", arvalid, 1'b1);
    check("9th arid",    arid,    4'hA);
    check("9th arlen",   arlen,   4'd2);
    nxt(); #1;
    nxt(); #1;
    check("hold arvalid", arvalid, 1'b1);
    check("cnt before 4", dbg_out_cnt, 4'd5);
    nxt(); arready = 1'b1; rsp_done = 1'b1; #1;
    check("coincident pre cnt", dbg_out_cnt, 4'd4);
    nxt(); arready = 1'b0; #1;
    check("coincident post cnt", dbg_out_cnt, 4'd4);
    check("coincident state", dbg_state, ST_IDLE);
    nxt(); #1; nxt(); #1; nxt(); #1;
    nxt(); rsp_done = 1'b0; #1;
    check("drain cnt", dbg_out_cnt, 4'd0);

    // Reset at beat 2 of a len=7 write.
    nxt(); set_req(1'b1, 1'b1, 4'd6, 32'h6000, 4'd7); #1;
    check("rst pop", req_ready, 1'b1);
    nxt(); req_valid = 1'b0; awready = 1'b1; #1;
    check("rst awvalid", awvalid, 1'b1);
    nxt(); awready = 1'b0; set_wd(1'b1, 64'h0123_4567_89AB_CDEF); wready = 1'b1; #1;
    check("rst beat0 wvalid", wvalid, 1'b1);
    check("rst beat0 wlast",  wlast,  1'b0);
    nxt(); #1;
    check("rst beat1 wd_ready", wd_ready, 1'b1);
    nxt(); areset = 1'b1; #1;
    check("rst beat2 wvalid", wvalid, 1'b1);
    check("rst beat2 cnt", dbg_out_cnt, 4'd1);
    nxt(); areset = 1'b0; #1;
    check("post rst wvalid", wvalid, 1'b0);
    check("post rst state",  dbg_state, ST_IDLE);
    check("post rst cnt",    dbg_out_cnt, 4'd0);
    check("post rst awvalid", awvalid, 1'b0);
    check("post rst wlast",  wlast, 1'b0);

    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
